spi_mstr_gen2: RTL and testbench
================================

// Module: spi_mstr_gen2
// PURPOSE
//  Parametrised SPI master, successor to the fixed 16-bit, mode-0, single-slave master.
//  Adds run-time CPOL/CPHA mode, a configurable word width and SCLK divider, and NUM_SS one-hot slave selects.
//  Fully synchronous to clk: no derived-clock flops; MISO is synchronised and sampled via clk enables.
//  Sits between the capture/trigger control logic and the off-chip ADC/DAC/EEPROM SPI slaves.
// PARAMETERS
//  DATA_W   16  bits per transfer (4..32)
//  CLK_DIV  16  clk cycles per SCLK half-period (even, >=4)
//  NUM_SS   1   number of slave-select lines (1..8)
// PORTS
//  clk      in   1               system clock
//  rst_n    in   1               reset, asynchronous, active-low
//  wrt      in   1               start request; accepted only in IDLE
//  cmd      in   DATA_W          word to shift out, MSB first
//  ss_sel   in   max(1,$clog2(NUM_SS))  slave index for this transfer
//  cpol     in   1               SCLK idle level for this transfer
//  cpha     in   1               0: sample on leading edge, 1: sample on trailing edge
//  MISO     in   1               serial in (asynchronous to clk)
//  SCLK     out  1               serial clock
//  MOSI     out  1               serial out
//  SS_n     out  NUM_SS          active-low selects, at most one low
//  busy     out  1               high from cycle after accept until DONE exits
//  done     out  1               one-cycle pulse; data valid from this cycle on
//  data     out  DATA_W          received word, held until next done
// BEHAVIOUR
//  Reset: state IDLE; SCLK=0, MOSI=0, SS_n all 1, busy=0, done=0, data=0, counters 0, latched cpol=0.
//  Accept (cycle 0: wrt=1 in IDLE): latch cmd, ss_sel, cpol, cpha; wrt in any other state is ignored.
//    ss_sel >= NUM_SS: no SS_n line asserts; the transfer still runs.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
//  SETUP (CLK_DIV cycles from cycle 1): SS_n[sel]=0, SCLK=cpol;
//    MOSI=cmd[MSB] when cpha=0, 0 when cpha=1.
//  SHIFT (2*DATA_W*CLK_DIV cycles): SCLK toggles at the start of each half-period.
//    Edge 1 is the leading edge. cpha=0: odd edges sample, even edges shift.
//    cpha=1: odd edges shift (MOSI = next bit), even edges sample.
//  Sampling: MISO passes through 2 flops; bit is captured from sync output 2 clk after the sample edge.
//    Capture is LSB-in: rx <= {rx[DATA_W-2:0], miso_s}.
//  HOLD (CLK_DIV cycles): SCLK=cpol, SS_n still low, last delayed sample lands here.
//  DONE (1 cycle): SS_n all 1, done=1, data<=rx, busy=1; next cycle IDLE, new wrt accepted there.
//  Latency: done high at cycle 1+CLK_DIV*(2*DATA_W+2) after accept (545 for defaults).
//  Bit counter DATA_W-wide range, terminal at DATA_W sample events; no wrap inside a transfer.
//  IDLE: SCLK = last latched cpol, MOSI=0, SS_n all 1.
//  Reset mid-transfer: immediate return to reset values; the partial word is discarded and data is cleared.
//  Back-to-back transfers: min gap SS_n high = 1 (DONE) + 1 (IDLE accept) cycles.
// STRUCTURE
//  spi_pkg: typedef enum logic[2:0] {IDLE,SETUP,SHIFT,HOLD,DONE} spi_state_t;
//           typedef struct packed {logic cpol; logic cpha;} spi_mode_t; SYNC_LAT=2 constant.
//  Sub-module spi_sclk_gen: divider counter + half-period edge strobes (lead/trail, sample/shift)
//    from CLK_DIV and latched mode; top holds the FSM, shift registers, MISO sync and SS decode.
// TESTING
//  1 Mode0, cmd=16'hA55A, loopback MOSI->MISO -> done at cycle 545, data=16'hA55A, 16 SCLK rises.
//  2 Modes 1/2/3 with slave model returning 16'h1234 -> data=16'h1234; SCLK idles at cpol; MOSI stable on sample edges.
//  3 NUM_SS=4, ss_sel=2 -> only SS_n[2] low, SS_n=4'b1011 during transfer; ss_sel=5 -> SS_n stays 4'b1111.
//  4 DATA_W=8, CLK_DIV=4, cmd=8'h81 -> done at cycle 1+4*18=73, 8 SCLK pulses.
//  5 wrt held high continuously -> transfers back-to-back; wrt pulses while busy are ignored.
//  6 rst_n low mid-SHIFT -> same cycle: SS_n all 1, SCLK=0, busy=0, data=0; clean transfer afterwards.

Source files
------------

// File: rtl/spi_mstr_gen2_pkg.sv
// Shared types and constants for the parametrised SPI master.
package spi_mstr_gen2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Depth of the MISO synchroniser; captured bits trail the sample edge by this many clk.
  localparam int SYNC_LAT = 2;

endpackage

// File: rtl/spi_mstr_gen2_sclk_gen.sv
// SCLK timing: half-period divider plus half-period index, producing the edge,
// sample and shift strobes one cycle ahead of the registered SCLK toggle.
module spi_mstr_gen2_sclk_gen #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run_i,
  input  logic                             cpha_i,
  output logic                             tick_o,
  output logic [$clog2(2*DATA_W+3)-1:0]    half_o,
  output logic                             edge_o,
  output logic                             sample_o,
  output logic                             shift_o
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HALF_W = $clog2(2*DATA_W+3);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV-1);
  localparam logic [HALF_W-1:0] HALF_END = HALF_W'(2*DATA_W);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              lead_s, trail_s;

  always_comb begin
    tick_o = run_i && (div_q == DIV_LAST);
    div_d  = tick_o ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    half_d = tick_o ? half_q + HALF_W'(1) : half_q;
    // Half index 0 is SETUP, so a tick there is edge 1 (leading); odd edges see an even index.
    edge_o   = tick_o && (half_q < HALF_END);
    lead_s   = edge_o && !half_q[0];
    trail_s  = edge_o && half_q[0];
    sample_o = cpha_i ? trail_s : lead_s;
    shift_o  = cpha_i ? lead_s : trail_s;
    half_o   = half_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= {DIV_W{1'b0}};
      half_q <= {HALF_W{1'b0}};
    end else if (!run_i) begin
      div_q  <= {DIV_W{1'b0}};
      half_q <= {HALF_W{1'b0}};
    end else begin
      div_q  <= div_d;
      half_q <= half_d;
    end
  end

endmodule

// File: rtl/spi_mstr_gen2.sv
// SPI master with run-time CPOL/CPHA, DATA_W-bit words, CLK_DIV divider and one-hot
// slave selects. Everything runs on clk; SCLK/MOSI/SS_n are plain registers.
module spi_mstr_gen2
  import spi_mstr_gen2_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 16,
  parameter int NUM_SS  = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        wrt,
  input  logic [DATA_W-1:0]                           cmd,
  input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
  input  logic                                        cpol,
  input  logic                                        cpha,
  input  logic                                        MISO,
  output logic                                        SCLK,
  output logic                                        MOSI,
  output logic [NUM_SS-1:0]                           SS_n,
  output logic                                        busy,
  output logic                                        done,
  output logic [DATA_W-1:0]                           data
);

  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int HALF_W = $clog2(2*DATA_W+3);
  localparam int BIT_W  = $clog2(DATA_W+1);
  localparam logic [HALF_W-1:0] HALF_END = HALF_W'(2*DATA_W);
  localparam logic [BIT_W-1:0]  BIT_END  = BIT_W'(DATA_W);

  spi_state_t          state_q, state_d;
  spi_mode_t           mode_q, mode_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d, ss_dec_s;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SYNC_LAT-1:0] sync_q, sync_d;
  logic [SYNC_LAT:0]   samp_q, samp_d;

  logic                run_s, accept_s, miso_s;
  logic                tick_s, edge_s, sample_s, shift_s;
  logic [HALF_W-1:0]   half_s;

  assign run_s    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign accept_s = (state_q == IDLE) && wrt;
  assign miso_s   = sync_q[SYNC_LAT-1];

  spi_mstr_gen2_sclk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (run_s),
    .cpha_i   (mode_q.cpha),
    .tick_o   (tick_s),
    .half_o   (half_s),
    .edge_o   (edge_s),
    .sample_o (sample_s),
    .shift_o  (shift_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wrt ? SETUP : IDLE;
      SETUP:   state_d = tick_s ? SHIFT : SETUP;
      SHIFT:   state_d = (tick_s && (half_s == HALF_END)) ? HOLD : SHIFT;
      HOLD:    state_d = tick_s ? DONE : HOLD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range ss_sel decodes to no select at all; the transfer still runs.
  always_comb begin
    ss_dec_s = {NUM_SS{1'b1}};
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SS_W'(i)) ss_dec_s[i] = 1'b0;
    end
  end

  always_comb begin
    mode_d = accept_s ? spi_mode_t'{cpol: cpol, cpha: cpha} : mode_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    tx_d   = tx_q;
    if (accept_s) begin
      sclk_d = cpol;
      // cpha=0 presents the MSB before the first (sampling) edge; cpha=1 shifts it out on edge 1.
      mosi_d = cpha ? 1'b0 : cmd[DATA_W-1];
      tx_d   = cpha ? cmd : {cmd[DATA_W-2:0], 1'b0};
    end else if (edge_s) begin
      sclk_d = ~sclk_q;
      if (shift_s) begin
        mosi_d = tx_q[DATA_W-1];
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
    end else if (state_d == HOLD) begin
      sclk_d = mode_q.cpol;
    end else if (state_d == IDLE) begin
      mosi_d = 1'b0;
    end

    if (accept_s)                                   ss_n_d = ss_dec_s;
    else if (state_d == DONE || state_d == IDLE)    ss_n_d = {NUM_SS{1'b1}};
    else                                            ss_n_d = ss_n_q;

    sync_d = {sync_q[SYNC_LAT-2:0], MISO};
    samp_d = {samp_q[SYNC_LAT-1:0], sample_s};

    rx_d  = rx_q;
    bit_d = bit_q;
    if (accept_s) begin
      rx_d  = {DATA_W{1'b0}};
      bit_d = {BIT_W{1'b0}};
    end else if (samp_q[SYNC_LAT] && (bit_q != BIT_END)) begin
      rx_d  = {rx_q[DATA_W-2:0], miso_s};
      bit_d = bit_q + BIT_W'(1);
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    data_d = (state_d == DONE) ? rx_d : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= spi_mode_t'(2'b00);
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= {NUM_SS{1'b1}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
      tx_q    <= {DATA_W{1'b0}};
      rx_q    <= {DATA_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      sync_q  <= {SYNC_LAT{1'b0}};
      samp_q  <= {(SYNC_LAT+1){1'b0}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      sync_q  <= sync_d;
      samp_q  <= samp_d;
    end
  end

  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign SS_n = ss_n_q;
  assign busy = busy_q;
  assign done = done_q;
  assign data = data_q;

endmodule

// File: tb/tb_spi_mstr_gen2.sv
// Scoreboard bench: a default-sized master (slave model / loopback) and an 8-bit,
// CLK_DIV=4, five-select master in loopback.
module tb_spi_mstr_gen2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: defaults
  logic        a_wrt, a_cpol, a_cpha, a_miso, a_sclk, a_mosi, a_busy, a_done;
  logic [15:0] a_cmd, a_data;
  logic [0:0]  a_sel, a_ss_n;
  // Instance B: DATA_W=8, CLK_DIV=4, NUM_SS=5
  logic        b_wrt, b_cpol, b_cpha, b_miso, b_sclk, b_mosi, b_busy, b_done;
  logic [7:0]  b_cmd, b_data;
  logic [2:0]  b_sel;
  logic [4:0]  b_ss_n;

  spi_mstr_gen2 u_dut_a (
    .clk(clk), .rst_n(rst_n), .wrt(a_wrt), .cmd(a_cmd), .ss_sel(a_sel), .cpol(a_cpol),
    .cpha(a_cpha), .MISO(a_miso), .SCLK(a_sclk), .MOSI(a_mosi), .SS_n(a_ss_n),
    .busy(a_busy), .done(a_done), .data(a_data)
  );

  spi_mstr_gen2 #(.DATA_W(8), .CLK_DIV(4), .NUM_SS(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wrt(b_wrt), .cmd(b_cmd), .ss_sel(b_sel), .cpol(b_cpol),
    .cpha(b_cpha), .MISO(b_miso), .SCLK(b_sclk), .MOSI(b_mosi), .SS_n(b_ss_n),
    .busy(b_busy), .done(b_done), .data(b_data)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] dat;
    logic [31:0] mosi;
    int          done_cyc;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // Slave model for A: presents a_resp on MISO and records what it sees on MOSI.
  logic        a_loop, slv_miso, a_sclk_p, a_ss_p;
  logic [15:0] a_resp, slv_sh, slv_rx;
  int          slv_edge, a_rises;
  assign a_miso = a_loop ? a_mosi : slv_miso;
  assign b_miso = b_mosi;

  always @(negedge clk) begin
    if (a_ss_p && !a_ss_n[0]) begin
      slv_edge <= 0;
      a_rises  <= 0;
      slv_rx   <= 16'h0000;
      slv_miso <= a_cpha ? 1'b0 : a_resp[15];
      slv_sh   <= a_cpha ? a_resp : {a_resp[14:0], 1'b0};
    end else if (!a_ss_n[0] && (a_sclk != a_sclk_p)) begin
      if (a_sclk) a_rises <= a_rises + 1;
      if (((slv_edge % 2) == 0) ^ a_cpha) begin
        slv_rx <= {slv_rx[14:0], a_mosi};
      end else begin
        slv_miso <= slv_sh[15];
        slv_sh   <= {slv_sh[14:0], 1'b0};
      end
      slv_edge <= slv_edge + 1;
    end
    a_sclk_p <= a_sclk;
    a_ss_p   <= a_ss_n[0];
  end

  logic b_sclk_p, b_busy_p;
  int   b_rises;
  always @(negedge clk) begin
    if (b_busy && !b_busy_p)      b_rises <= 0;
    else if (b_sclk && !b_sclk_p) b_rises <= b_rises + 1;
    b_sclk_p <= b_sclk;
    b_busy_p <= b_busy;
  end

  // Scoreboard pops: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (a_done) begin
      chk_eq("a_q_nonempty", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk_eq("a_latency", cyc, ea.done_cyc);
        chk_eq("a_data", 32'(a_data), ea.dat);
        chk_eq("a_sclk_rises", a_rises, 32'd16);
        chk_eq("a_slave_mosi", 32'(slv_rx), ea.mosi);
        chk_eq("a_done_busy", 32'(a_busy), 32'd1);
        chk_eq("a_done_ss", 32'(a_ss_n), 32'd1);
      end
    end
    if (b_done) begin
      chk_eq("b_q_nonempty", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk_eq("b_latency", cyc, eb.done_cyc);
        chk_eq("b_data", 32'(b_data), eb.dat);
        chk_eq("b_sclk_rises", b_rises, 32'd8);
        chk_eq("b_done_ss", 32'(b_ss_n), 32'h1f);
      end
    end
  end

  task automatic wait_a_done();
    int k = 0;
    while (!a_done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk_eq("a_done_seen", 32'(a_done), 32'd1);
  endtask

  task automatic run_a(input logic [15:0] cmd, input logic cpol, input logic cpha,
                       input logic loop, input logic [15:0] resp);
    @(negedge clk);
    a_cmd = cmd; a_cpol = cpol; a_cpha = cpha; a_loop = loop; a_resp = resp; a_sel = 1'b0;
    a_wrt = 1'b1;
    qa.push_back('{dat: 32'(loop ? cmd : resp), mosi: 32'(cmd), done_cyc: cyc + 545});
    @(negedge clk);
    a_wrt = 1'b0;
    chk_eq("a_setup_busy", 32'(a_busy), 32'd1);
    chk_eq("a_setup_ss", 32'(a_ss_n), 32'd0);
    chk_eq("a_setup_sclk", 32'(a_sclk), 32'(cpol));
    chk_eq("a_setup_mosi", 32'(a_mosi), 32'(cpha ? 1'b0 : cmd[15]));
    wait_a_done();
    @(negedge clk);
    chk_eq("a_idle_sclk", 32'(a_sclk), 32'(cpol));
    chk_eq("a_idle_ss", 32'(a_ss_n), 32'd1);
    chk_eq("a_idle_busy", 32'(a_busy), 32'd0);
    chk_eq("a_idle_done", 32'(a_done), 32'd0);
    chk_eq("a_idle_mosi", 32'(a_mosi), 32'd0);
  endtask

  task automatic run_b(input logic [7:0] cmd, input logic [2:0] sel, input logic cpol,
                       input logic cpha, input logic [4:0] exp_ss);
    int k = 0;
    @(negedge clk);
    b_cmd = cmd; b_sel = sel; b_cpol = cpol; b_cpha = cpha; b_wrt = 1'b1;
    qb.push_back('{dat: 32'(cmd), mosi: 32'(cmd), done_cyc: cyc + 73});
    @(negedge clk);
    b_wrt = 1'b0;
    chk_eq("b_setup_ss", 32'(b_ss_n), 32'(exp_ss));
    chk_eq("b_setup_sclk", 32'(b_sclk), 32'(cpol));
    chk_eq("b_setup_mosi", 32'(b_mosi), 32'(cpha ? 1'b0 : cmd[7]));
    while (!b_done && k < 500) begin
      @(negedge clk);
      k++;
      if (!b_done) chk_eq("b_mid_ss", 32'(b_ss_n), 32'(exp_ss));
    end
    chk_eq("b_done_seen", 32'(b_done), 32'd1);
    @(negedge clk);
    chk_eq("b_idle_sclk", 32'(b_sclk), 32'(cpol));
  endtask

  initial begin
    int t;
    int k;
    rst_n = 1'b0;
    a_wrt = 1'b0; a_cmd = 16'h0000; a_sel = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0;
    a_loop = 1'b1; a_resp = 16'h0000;
    b_wrt = 1'b0; b_cmd = 8'h00; b_sel = 3'd0; b_cpol = 1'b0; b_cpha = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_a_sclk", 32'(a_sclk), 32'd0);
    chk_eq("rst_a_mosi", 32'(a_mosi), 32'd0);
    chk_eq("rst_a_ss", 32'(a_ss_n), 32'd1);
    chk_eq("rst_a_busy", 32'(a_busy), 32'd0);
    chk_eq("rst_a_done", 32'(a_done), 32'd0);
    chk_eq("rst_a_data", 32'(a_data), 32'd0);
    chk_eq("rst_b_ss", 32'(b_ss_n), 32'h1f);
    rst_n = 1'b1;

    // Loopback mode 0, then slave-returned word in modes 1..3
    run_a(16'hA55A, 1'b0, 1'b0, 1'b1, 16'h0000);
    run_a(16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h1234);
    run_a(16'h0F3C, 1'b1, 1'b0, 1'b0, 16'h1234);
    run_a(16'h7E81, 1'b1, 1'b1, 1'b0, 16'h1234);

    // Small instance: select decode incl. last valid and out-of-range index
    run_b(8'h81, 3'd2, 1'b0, 1'b0, 5'b11011);
    run_b(8'h3C, 3'd5, 1'b1, 1'b1, 5'b11111);
    run_b(8'hE7, 3'd4, 1'b0, 1'b1, 5'b01111);

    // wrt held high: back-to-back, cmd changes while busy are not taken until IDLE
    @(negedge clk);
    a_cmd = 16'hC3E1; a_cpol = 1'b0; a_cpha = 1'b0; a_loop = 1'b1; a_wrt = 1'b1;
    t = cyc;
    qa.push_back('{dat: 32'h0000C3E1, mosi: 32'h0000C3E1, done_cyc: t + 545});
    qa.push_back('{dat: 32'h00005A0F, mosi: 32'h00005A0F, done_cyc: t + 1091});
    @(negedge clk);
    a_cmd = 16'h5A0F;
    while (cyc < t + 547) @(negedge clk);
    a_wrt = 1'b0;
    k = 0;
    while (qa.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk_eq("a_b2b_drained", qa.size(), 32'd0);

    // Reset in the middle of SHIFT with cpol=1
    @(negedge clk);
    a_cmd = 16'h0FF0; a_cpol = 1'b1; a_cpha = 1'b0; a_loop = 1'b1; a_wrt = 1'b1;
    @(negedge clk);
    a_wrt = 1'b0;
    repeat (100) @(negedge clk);
    chk_eq("pre_rst_busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_ss", 32'(a_ss_n), 32'd1);
    chk_eq("mid_rst_sclk", 32'(a_sclk), 32'd0);
    chk_eq("mid_rst_busy", 32'(a_busy), 32'd0);
    chk_eq("mid_rst_data", 32'(a_data), 32'd0);
    chk_eq("mid_rst_mosi", 32'(a_mosi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(16'h6B29, 1'b0, 1'b0, 1'b1, 16'h0000);

    repeat (4) @(negedge clk);
    chk_eq("a_q_empty_end", qa.size(), 32'd0);
    chk_eq("b_q_empty_end", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
